// File: rtl/level_count_ctrl_pkg.sv
// Shared types and helpers for the level-duration counter.
// State encoding, tick divider sizing and default clock constants.
package level_count_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int DEF_TICK_HZ     = 2;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Never narrower than one bit, even for the minimum divide of 2.
    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/level_count_ctrl_tick_gen.sv
// Tick enable generator: one-cycle pulse every DIV enabled cycles.
// Synchronous clear restarts the period from zero.
module tick_gen
    import level_count_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int W = div_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_div;

    always_ff @(posedge clk_in) begin
        if (reset || i_clr) begin
            r_div <= '0;
        end else if (i_en) begin
            r_div <= (r_div == LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign o_tick = i_en && (r_div == LAST);

endmodule

// File: rtl/level_count_ctrl.sv
// Arm/clear controller timing how many ticks a level stays high.
// Define LEVEL_COUNT_CTRL_DEBOUNCE_EN to debounce the synchronised level.
module level_count_ctrl
    import level_count_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int TICK_HZ     = DEF_TICK_HZ,
    parameter int COUNT_BITS  = 8
`ifdef LEVEL_COUNT_CTRL_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES  = 16
`endif
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  i_lv_in,
    input  logic                  i_arm,
    input  logic                  i_clear,
    input  logic [COUNT_BITS-1:0] i_limit,
    output logic [COUNT_BITS-1:0] o_count,
    output logic [1:0]            o_state,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_limit_hit,
    output logic                  o_tick
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);

    state_t                r_state;
    state_t                w_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_lv_p;
    logic                  w_lv;
    logic                  w_rise;
    logic                  w_div_tick;
    logic                  r_tick;
    logic                  r_limit_hit;
    logic [COUNT_BITS-1:0] r_count;
    logic [COUNT_BITS-1:0] r_limit_q;
    logic [COUNT_BITS-1:0] w_count_inc;
    logic [COUNT_BITS-1:0] w_lim_sel;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lv_p  <= 1'b0;
        end else begin
            r_sync1 <= i_lv_in;
            r_sync2 <= r_sync1;
            r_lv_p  <= w_lv;
        end
    end

`ifdef LEVEL_COUNT_CTRL_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_deb;

    // Output follows only once the new level has persisted long enough.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_deb_cnt <= '0;
            r_deb     <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            r_deb_cnt <= '0;
            r_deb     <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_lv = r_deb;
`else
    assign w_lv = r_sync2;
`endif

    assign w_rise      = w_lv && !r_lv_p;
    assign w_count_inc = r_count + 1'b1;
    assign w_lim_sel   = (i_limit == '0) ? '1 : i_limit;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_in (clk_in),
        .reset  (reset),
        .i_clr  (i_clear || (r_state != COUNTING)),
        .i_en   (r_state == COUNTING),
        .o_tick (w_div_tick)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (i_arm) w_next = ARMED;
                ARMED:    if (w_rise) w_next = COUNTING;
                COUNTING: begin
                    if (!w_lv) begin
                        w_next = DONE;
                    end else if (w_div_tick && (w_count_inc == r_limit_q)) begin
                        w_next = DONE;
                    end
                end
                DONE:     if (i_arm) w_next = ARMED;
                default:  w_next = IDLE;
            endcase
        end
    end

    // A falling level wins over a coincident tick, so no increment then.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_count     <= '0;
            r_limit_hit <= 1'b0;
            r_tick      <= 1'b0;
            r_limit_q   <= '0;
        end else begin
            r_tick <= 1'b0;
            if (i_clear) begin
                r_count     <= '0;
                r_limit_hit <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, ARMED: begin
                        if (i_arm) r_limit_q <= w_lim_sel;
                    end
                    COUNTING: begin
                        if (w_lv && w_div_tick) begin
                            r_tick  <= 1'b1;
                            r_count <= w_count_inc;
                            if (w_count_inc == r_limit_q) r_limit_hit <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (i_arm) begin
                            r_count     <= '0;
                            r_limit_hit <= 1'b0;
                            r_limit_q   <= w_lim_sel;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_state     = r_state;
        o_busy      = (r_state == ARMED) || (r_state == COUNTING);
        o_done      = (r_state == DONE);
        o_count     = r_count;
        o_limit_hit = r_limit_hit;
        o_tick      = r_tick;
    end

endmodule

// File: tb/tb_level_count_ctrl.sv
// Bench for level_count_ctrl: directed steps plus random traffic
// against a cycle-stepped behavioural model (DIV=10).
module tb_level_count_ctrl;

    localparam int DIV = 10;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       lv = 1'b0, arm = 1'b0, clr = 1'b0;
    logic [7:0] lim = 8'd0;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       busy, done, hit, tick;

    logic       lv3 = 1'b0, arm3 = 1'b0, clr3 = 1'b0;
    logic [2:0] lim3 = 3'd0;
    logic [2:0] cnt3;
    logic [1:0] st3;
    logic       busy3, done3, hit3, tick3;

    int n_checks = 0;
    int n_err    = 0;

    // Model: mode 0..3 = idle/armed/counting/done
    int m_mode, m_cnt, m_el, m_lim;
    bit m_hit, m_tick;
    bit hq[$];

    always #5 clk_in = ~clk_in;

    level_count_ctrl #(
        .CLK_FREQ_HZ (20),
        .TICK_HZ     (2),
        .COUNT_BITS  (8)
    ) u_dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .i_lv_in     (lv),
        .i_arm       (arm),
        .i_clear     (clr),
        .i_limit     (lim),
        .o_count     (cnt),
        .o_state     (st),
        .o_busy      (busy),
        .o_done      (done),
        .o_limit_hit (hit),
        .o_tick      (tick)
    );

    level_count_ctrl #(
        .CLK_FREQ_HZ (20),
        .TICK_HZ     (2),
        .COUNT_BITS  (3)
    ) u_dut3 (
        .clk_in      (clk_in),
        .reset       (reset),
        .i_lv_in     (lv3),
        .i_arm       (arm3),
        .i_clear     (clr3),
        .i_limit     (lim3),
        .o_count     (cnt3),
        .o_state     (st3),
        .o_busy      (busy3),
        .o_done      (done3),
        .o_limit_hit (hit3),
        .o_tick      (tick3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit lvs, rise;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_el = 0; m_lim = 0;
            m_hit = 0; m_tick = 0;
            hq = {1'b0, 1'b0, 1'b0};
        end else begin
            lvs    = hq[1];
            rise   = hq[1] && !hq[2];
            m_tick = 0;
            if (clr) begin
                m_mode = 0; m_cnt = 0; m_hit = 0; m_el = 0;
            end else if (m_mode == 0 || m_mode == 1) begin
                if (arm) m_lim = (lim == 0) ? 255 : int'(lim);
                if (m_mode == 0 && arm) m_mode = 1;
                else if (m_mode == 1 && rise) begin
                    m_mode = 2; m_el = 0;
                end
            end else if (m_mode == 2) begin
                if (!lvs) begin
                    m_mode = 3;
                end else begin
                    m_el++;
                    if (m_el % DIV == 0) begin
                        m_tick = 1;
                        m_cnt++;
                        if (m_cnt == m_lim) begin
                            m_mode = 3; m_hit = 1;
                        end
                    end
                end
            end else if (arm) begin
                m_mode = 1; m_cnt = 0; m_hit = 0;
                m_lim = (lim == 0) ? 255 : int'(lim);
            end
            hq.push_front(lv);
            void'(hq.pop_back());
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        chk("m_state", st, m_mode);
        chk("m_count", cnt, m_cnt);
        chk("m_busy", busy, (m_mode == 1 || m_mode == 2));
        chk("m_done", done, (m_mode == 3));
        chk("m_hit", hit, m_hit);
        chk("m_tick", tick, m_tick);
    endtask

    task automatic wait_state(input logic [1:0] s, input int maxc,
                              output int n);
        n = 0;
        while (st !== s && n < maxc) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n, tq[$];
        bit seen;

        hq = {1'b0, 1'b0, 1'b0};
        repeat (2) cycle();
        reset = 1'b0;

        // 1: idle after reset
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick === 1'b1) seen = 1;
        end
        chk("t1_count", cnt, 0);
        chk("t1_state", st, 0);
        chk("t1_done", done, 0);
        chk("t1_busy", busy, 0);
        chk("t1_tick", seen, 0);

        // 2: unlimited, level high 35 cycles after entry
        lim = 8'd0; arm = 1'b1;
        cycle();
        arm = 1'b0; lv = 1'b1;
        wait_state(2'd2, 10, n);
        chk("t2_enter", st, 2);
        chk("t2_rise_lat", n, 3);
        for (int i = 1; i <= 35; i++) begin
            cycle();
            if (tick === 1'b1) tq.push_back(i);
        end
        chk("t2_nticks", tq.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("t2_tick_at", (k < tq.size()) ? tq[k] : 0, 10 * (k + 1));
        lv = 1'b0;
        wait_state(2'd3, 10, n);
        chk("t2_done_lat", n, 3);
        chk("t2_count", cnt, 3);
        chk("t2_done", done, 1);
        chk("t2_hit", hit, 0);

        // 3: limit 2, level high continuously
        lim = 8'd2; arm = 1'b1;
        cycle();
        arm = 1'b0; lv = 1'b1;
        chk("t3_armed", st, 1);
        chk("t3_cnt0", cnt, 0);
        wait_state(2'd2, 10, n);
        chk("t3_rise_lat", n, 3);
        wait_state(2'd3, 40, n);
        chk("t3_done_at", n, 20);
        chk("t3_tick", tick, 1);
        chk("t3_count", cnt, 2);
        chk("t3_hit", hit, 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (tick === 1'b1) seen = 1;
        end
        chk("t3_no_tick", seen, 0);

        // 5: level already high at arm stays armed
        lim = 8'd0; arm = 1'b1;
        cycle();
        arm = 1'b0;
        repeat (10) cycle();
        chk("t5_armed", st, 1);
        chk("t5_cnt", cnt, 0);
        lv = 1'b0;
        repeat (5) cycle();
        lv = 1'b1;
        wait_state(2'd2, 10, n);
        chk("t5_rise_lat", n, 3);

        // 4: clear at count=1, then arm+clear in idle
        repeat (12) cycle();
        chk("t4_cnt1", cnt, 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t4_idle", st, 0);
        chk("t4_cnt0", cnt, 0);
        arm = 1'b1; clr = 1'b1;
        cycle();
        arm = 1'b0; clr = 1'b0;
        chk("t4_prio", st, 0);
        lv = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            arm = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) lv = ~lv;
            case ($urandom_range(0, 3))
                0:       lim = 8'd0;
                1:       lim = 8'($urandom_range(1, 3));
                default: lim = 8'($urandom_range(1, 255));
            endcase
            cycle();
        end
        arm = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0; lv = 1'b0;

        // 6: 3-bit saturation, then reset mid-count
        lim3 = 3'd0; arm3 = 1'b1;
        cycle();
        arm3 = 1'b0; lv3 = 1'b1;
        n = 0;
        while (st3 !== 2'd3 && n < 120) begin
            cycle();
            n++;
        end
        chk("t6_done", done3, 1);
        chk("t6_count", cnt3, 7);
        chk("t6_hit", hit3, 1);
        chk("t6_cycles", n, 73);
        arm3 = 1'b1;
        cycle();
        arm3 = 1'b0; lv3 = 1'b0;
        repeat (4) cycle();
        lv3 = 1'b1;
        n = 0;
        while (st3 !== 2'd2 && n < 10) begin
            cycle();
            n++;
        end
        chk("t6_enter", st3, 2);
        repeat (15) cycle();
        chk("t6_mid_cnt", cnt3, 1);
        reset = 1'b1;
        cycle();
        chk("t6_rst_state", st3, 0);
        chk("t6_rst_count", cnt3, 0);
        chk("t6_rst_busy", busy3, 0);
        chk("t6_rst_done", done3, 0);
        chk("t6_rst_hit", hit3, 0);
        chk("t6_rst_tick", tick3, 0);
        reset = 1'b0; lv3 = 1'b0;
        repeat (3) cycle();
        chk("t6_post_state", st3, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
